vga_sync_monitor: RTL

Receive-side checker for the 640x480 VGA timing produced by the display driver. It samples `h_sync`, `v_sync` and `display_on` on pixel-enable cycles and recovers the active-area pixel coordinates. It measures line length and frame height and declares lock after consecutive conforming frames. It sits beside the driver, or on a loopback of its pins, and feeds the game's self-test and status LEDs.

---
 rtl/vga_sync_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side checker for VGA sync timing: recovers active-area coordinates,
// measures line/frame geometry and declares lock after consecutive good frames.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        px_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        display_on,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [11:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        err
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0]  Y_LAST_C   = 10'(V_ACTIVE - 1);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
  localparam logic [11:0] H_PRESAT_C = 12'hFFE;

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [11:0] a_cnt_q, a_cnt_d;
  logic [9:0]  act_lines_q, act_lines_d;
  logic [3:0]  good_q, good_d;
  logic        line_seen_q, line_seen_d;
  logic        line_bad_q, line_bad_d;
  logic [9:0]  x_pos_q, x_pos_d;
  logic [9:0]  y_pos_q, y_pos_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic [11:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  logic        hs_fall, vs_fall, checking;
  logic        line_ok, frame_ok, line_fail, frame_fail, sat;
  logic [11:0] meas_len, a_base;
  logic [3:0]  good_inc;

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    a_cnt_d       = a_cnt_q;
    act_lines_d   = act_lines_q;
    good_d        = good_q;
    line_seen_d   = line_seen_q;
    line_bad_d    = line_bad_q;
    x_pos_d       = x_pos_q;
    y_pos_d       = y_pos_q;
    pix_valid_d   = pix_valid_q;
    frame_start_d = 1'b0;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    err_d         = 1'b0;

    hs_fall    = hs_prev_q & ~h_sync;
    vs_fall    = vs_prev_q & ~v_sync;
    checking   = (state_q != SEARCH);
    meas_len   = (h_cnt_q == '1) ? '1 : h_cnt_q + 12'd1;
    line_ok    = (meas_len == H_TOTAL_C) && ((a_cnt_q == '0) || (a_cnt_q == H_ACTIVE_C));
    frame_ok   = (v_cnt_q == V_TOTAL_C) && (act_lines_q == V_ACTIVE_C);
    line_fail  = checking && hs_fall && line_seen_q && !line_ok;
    frame_fail = checking && vs_fall && !frame_ok;
    sat        = checking && !hs_fall && (h_cnt_q == H_PRESAT_C);
    a_base     = hs_fall ? '0 : a_cnt_q;
    good_inc   = good_q + 4'd1;

    if (px_en) begin
      hs_prev_d   = h_sync;
      vs_prev_d   = v_sync;
      pix_valid_d = display_on;

      if (hs_fall) begin
        line_len_d = meas_len;
        h_cnt_d    = '0;
        if (v_cnt_q != '1) v_cnt_d = v_cnt_q + 10'd1;
        if (a_cnt_q != '0) begin
          y_pos_d = (y_pos_q == Y_LAST_C) ? '0 : y_pos_q + 10'd1;
          if (act_lines_q != '1) act_lines_d = act_lines_q + 10'd1;
        end
      end else if (h_cnt_q != '1) begin
        h_cnt_d = h_cnt_q + 12'd1;
      end

      // A pixel sampled together with the hsync edge is the first of the new line
      a_cnt_d = a_base;
      if (display_on) begin
        x_pos_d = a_base[9:0];
        if (a_base != '1) a_cnt_d = a_base + 12'd1;
      end

      // vsync edge overrides the per-line updates; a coincident hsync edge is line 0
      if (vs_fall) begin
        frame_start_d = 1'b1;
        frame_lines_d = v_cnt_q;
        v_cnt_d       = hs_fall ? 10'd1 : 10'd0;
        y_pos_d       = '0;
        act_lines_d   = '0;
      end

      if (state_q == SEARCH) begin
        if (vs_fall) begin
          state_d     = ACQUIRE;
          good_d      = '0;
          line_seen_d = hs_fall;
          line_bad_d  = 1'b0;
        end
      end else begin
        if (hs_fall) line_seen_d = 1'b1;
        if (sat) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = SEARCH;
        end else if (line_fail || frame_fail) begin
          err_d      = 1'b1;
          good_d     = '0;
          state_d    = ACQUIRE;
          line_bad_d = !vs_fall;
        end else if (vs_fall) begin
          line_bad_d = 1'b0;
          if (state_q == ACQUIRE && !line_bad_q) begin
            good_d = good_inc;
            if (good_inc >= LOCK_C) state_d = LOCKED;
          end
        end
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      a_cnt_q       <= '0;
      act_lines_q   <= '0;
      good_q        <= '0;
      line_seen_q   <= 1'b0;
      line_bad_q    <= 1'b0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      a_cnt_q       <= a_cnt_d;
      act_lines_q   <= act_lines_d;
      good_q        <= good_d;
      line_seen_q   <= line_seen_d;
      line_bad_q    <= line_bad_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule
